// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin read/write port arbiter for a simple dual-port BRAM
// Optional write-first collision bypass: BRAM_ARB_BYPASS_EN
module bram_port_arbiter #(
   parameter int NUM_RD     = 4,
   parameter int NUM_WR     = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int ID_W       = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_RD-1:0]              rd_req_valid,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_req_addr,
   output logic [NUM_RD-1:0]              rd_req_ready,
   input  logic [NUM_WR-1:0]              wr_req_valid,
   input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_req_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_req_data,
   output logic [NUM_WR-1:0]              wr_req_ready,
   output logic                           rsp_valid,
   output logic [ID_W-1:0]                rsp_id,
   output logic [DATA_WIDTH-1:0]          rsp_data,
   output logic                           bram_we,
   output logic [ADDR_WIDTH-1:0]          bram_waddr,
   output logic [DATA_WIDTH-1:0]          bram_wdata,
   output logic [ADDR_WIDTH-1:0]          bram_raddr,
   input  logic [DATA_WIDTH-1:0]          bram_rdata
);
   localparam int WP_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

   logic [ID_W-1:0]       last_rd, rd_id1;
   logic [WP_W-1:0]       last_wr;
   logic [NUM_RD-1:0]     rd_rot;
   logic [NUM_WR-1:0]     wr_rot;
   int                    rd_pos, wr_pos;
   logic                  rd_any, wr_any, rd_v1;
   logic [ADDR_WIDTH-1:0] rd_addr_sel, wr_addr_sel;
   logic [DATA_WIDTH-1:0] wr_data_sel;

   // Rotate requests so bit 0 is the requester just after the last grant.
   always_comb begin
      rd_rot = NUM_RD'({rd_req_valid, rd_req_valid} >> (int'(last_rd) + 1));
      rd_any = 1'b0;
      rd_pos = 0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (!rd_any && rd_rot[i]) begin
            rd_any = 1'b1;
            rd_pos = int'(last_rd) + 1 + i;
         end
      end
      if (rd_pos >= NUM_RD) rd_pos = rd_pos - NUM_RD;
      rd_req_ready = '0;
      rd_addr_sel  = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (rd_any && rd_pos == i) begin
            rd_req_ready[i] = 1'b1;
            rd_addr_sel     = rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   always_comb begin
      wr_rot = NUM_WR'({wr_req_valid, wr_req_valid} >> (int'(last_wr) + 1));
      wr_any = 1'b0;
      wr_pos = 0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (!wr_any && wr_rot[i]) begin
            wr_any = 1'b1;
            wr_pos = int'(last_wr) + 1 + i;
         end
      end
      if (wr_pos >= NUM_WR) wr_pos = wr_pos - NUM_WR;
      wr_req_ready = '0;
      wr_addr_sel  = '0;
      wr_data_sel  = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (wr_any && wr_pos == i) begin
            wr_req_ready[i] = 1'b1;
            wr_addr_sel     = wr_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_sel     = wr_req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_rd    <= ID_W'(NUM_RD - 1);
         last_wr    <= WP_W'(NUM_WR - 1);
         bram_we    <= 1'b0;
         bram_waddr <= '0;
         bram_wdata <= '0;
         bram_raddr <= '0;
         rd_v1      <= 1'b0;
         rd_id1     <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
      end else begin
         bram_we <= wr_any;
         if (wr_any) begin
            last_wr    <= WP_W'(wr_pos);
            bram_waddr <= wr_addr_sel;
            bram_wdata <= wr_data_sel;
         end
         rd_v1 <= rd_any;
         if (rd_any) begin
            last_rd    <= ID_W'(rd_pos);
            rd_id1     <= ID_W'(rd_pos);
            bram_raddr <= rd_addr_sel;
         end
         rsp_valid <= rd_v1;
         rsp_id    <= rd_id1;
      end
   end

`ifdef BRAM_ARB_BYPASS_EN
   logic                  coll_q;
   logic [DATA_WIDTH-1:0] byp_data;

   // Read and write hit the BRAM on the same edge: return the write data instead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_q   <= 1'b0;
         byp_data <= '0;
      end else begin
         coll_q   <= rd_v1 && bram_we && (bram_waddr == bram_raddr);
         byp_data <= bram_wdata;
      end
   end

   assign rsp_data = coll_q ? byp_data : bram_rdata;
`else
   assign rsp_data = bram_rdata;
`endif

endmodule
